spi_minion_arbiter: RTL

//   Shares one SPI minion link between NREQ on-chip source/sink pairs; sits between spi_Minion and the consumers.

---
 rtl/spi_arb_pkg.sv | 25 ++
 rtl/arb_round_robin.sv | 41 ++++
 rtl/spi_minion_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/spi_arb_pkg.sv
// Shared derivations, frame field positions and FSM state for spi_minion_arbiter.
package spi_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_e;

    function automatic int addr_bits_f(input int nreq);
        return $clog2(nreq);
    endfunction

    function automatic int pw_f(input int nbits, input int nreq);
        return nbits - 1 - $clog2(nreq);
    endfunction

    function automatic int val_pos_f(input int nbits);
        return nbits - 1;
    endfunction

    function automatic int addr_msb_f(input int nbits);
        return nbits - 2;
    endfunction

endpackage

// File: rtl/arb_round_robin.sv
// Combinational round-robin picker: first asserted request at or above ptr, with wrap.
module arb_round_robin
    import spi_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]              req,
    input  logic [addr_bits_f(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]              grant,
    output logic [addr_bits_f(NREQ)-1:0] grant_idx,
    output logic                         grant_any
);

    localparam int AB = addr_bits_f(NREQ);

    logic [NREQ-1:0] rot_req;
    logic [AB-1:0]   offset;

    // rot_req[k] is the request k places above the pointer
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
            logic [AB-1:0] src;
            assign src         = ptr + AB'(gi);
            assign rot_req[gi] = req[src];
        end
    endgenerate

    always_comb begin
        offset = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot_req[k]) begin
                offset = AB'(k);
            end
        end
    end

    assign grant_any = |rot_req;
    assign grant_idx = ptr + offset;
    assign grant     = grant_any ? (NREQ'(1) << grant_idx) : '0;

endmodule

// File: rtl/spi_minion_arbiter.sv
// Shares one SPI minion link between NREQ source/sink pairs.
// Optional saturating drop counter enabled by defining SPI_ARB_DROP_CNT_EN.
module spi_minion_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NBITS = 16,
    parameter int NREQ  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  pull_en,
    output logic [NBITS-1:0]      pull_msg,
    input  logic                  push_en,
    input  logic [NBITS-1:0]      push_msg,
    input  logic [NREQ-1:0]       in_val,
    input  logic [NREQ*pw_f(NBITS, NREQ)-1:0] in_msg,
    output logic [NREQ-1:0]       in_rdy,
    output logic [NREQ-1:0]       out_val,
    output logic [NREQ*pw_f(NBITS, NREQ)-1:0] out_msg,
    input  logic [NREQ-1:0]       out_rdy,
    output logic [7:0]            drop_cnt
);

    localparam int ADDR_BITS = addr_bits_f(NREQ);
    localparam int PW        = pw_f(NBITS, NREQ);
    localparam int VAL_POS   = val_pos_f(NBITS);
    localparam int ADDR_MSB  = addr_msb_f(NBITS);

    generate
        if (PW < NREQ) begin : g_bad_pw
            $error("spi_minion_arbiter: payload width must be >= NREQ to carry the status bits");
        end
    endgenerate

    arb_state_e            state_q, state_d;
    logic [ADDR_BITS-1:0]  ptr_q, ptr_d;
    logic [NREQ-1:0]       out_val_q, out_val_d;
    logic [NREQ*PW-1:0]    out_msg_q, out_msg_d;

    logic [NREQ-1:0]       grant;
    logic [ADDR_BITS-1:0]  grant_idx;
    logic                  grant_any;

    logic                  push_live;
    logic                  push_frame_val;
    logic [ADDR_BITS-1:0]  push_addr;
    logic [PW-1:0]         push_payload;
    logic [NREQ-1:0]       accept;

    arb_round_robin #(.NREQ(NREQ)) u_rr (
        .req       (in_val),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign push_live      = push_en && (state_q == XFER);
    assign push_frame_val = push_msg[VAL_POS];
    assign push_addr      = push_msg[ADDR_MSB -: ADDR_BITS];
    assign push_payload   = push_msg[PW-1:0];

    // Push completes a transfer before a same-cycle pull can start the next one
    always_comb begin
        state_d = state_q;
        if (push_en) begin
            state_d = IDLE;
        end
        if (pull_en) begin
            state_d = XFER;
        end
    end

    always_comb begin
        pull_msg = '0;
        in_rdy   = '0;
        ptr_d    = ptr_q;
        if (pull_en && grant_any) begin
            pull_msg[VAL_POS]               = 1'b1;
            pull_msg[ADDR_MSB -: ADDR_BITS] = grant_idx;
            pull_msg[PW-1:0]                = in_msg[grant_idx*PW +: PW];
            in_rdy                          = grant;
            ptr_d                           = grant_idx + ADDR_BITS'(1);
        end else begin
            pull_msg[NREQ-1:0] = out_val_q;
        end
    end

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_dest
            logic hit;
            assign hit        = push_live && push_frame_val && (push_addr == ADDR_BITS'(gi));
            assign accept[gi] = hit && (!out_val_q[gi] || out_rdy[gi]);

            always_comb begin
                out_val_d[gi]             = out_val_q[gi];
                out_msg_d[gi*PW +: PW]    = out_msg_q[gi*PW +: PW];
                if (accept[gi]) begin
                    out_val_d[gi]          = 1'b1;
                    out_msg_d[gi*PW +: PW] = push_payload;
                end else if (out_val_q[gi] && out_rdy[gi]) begin
                    out_val_d[gi]          = 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            out_val_q <= '0;
            out_msg_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            out_val_q <= out_val_d;
            out_msg_q <= out_msg_d;
        end
    end

    assign out_val = out_val_q;
    assign out_msg = out_msg_q;

`ifdef SPI_ARB_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;
    logic       drop;

    // A push arriving outside a transfer is lost just like one refused by a full buffer
    assign drop = (push_en && (state_q == IDLE)) ||
                  (push_live && push_frame_val && !(|accept));

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt_q <= 8'h00;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = 8'h00;
`endif

endmodule
